// File: rtl/adc_pkg.sv
// adc_pkg: shared channel count, word width and sequencer state type for simpleadc consumers.
package adc_pkg;
    localparam int NUM_CH = 8;
    localparam int ADC_W  = 12;

    typedef logic [ADC_W-1:0] adc_word_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;
endpackage

// File: rtl/adc_tick_gen.sv
// adc_tick_gen: free-running divider, TICK high for one cycle every TICK_DIV cycles.
module adc_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic CLOCK,
    input  logic RESET,
    output logic TICK
);
    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0] cnt_q, cnt_d;

    assign TICK  = cnt_q == TW'(TICK_DIV - 1);
    assign cnt_d = TICK ? '0 : cnt_q + TW'(1);

    always_ff @(posedge CLOCK or negedge RESET)
        if (!RESET) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/adc_chan_avg.sv
// adc_chan_avg: snapshots CH0..CH7 each tick and box-car averages them over 2^AVG_LOG2 samples.
// Optional running-max peak registers are built when ADC_PEAK_HOLD_EN is defined.
module adc_chan_avg import adc_pkg::*; #(
    parameter int TICK_DIV = 50000,
    parameter int AVG_LOG2 = 4
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [11:0] CH0,
    input  logic [11:0] CH1,
    input  logic [11:0] CH2,
    input  logic [11:0] CH3,
    input  logic [11:0] CH4,
    input  logic [11:0] CH5,
    input  logic [11:0] CH6,
    input  logic [11:0] CH7,
    output logic [11:0] AVG0,
    output logic [11:0] AVG1,
    output logic [11:0] AVG2,
    output logic [11:0] AVG3,
    output logic [11:0] AVG4,
    output logic [11:0] AVG5,
    output logic [11:0] AVG6,
    output logic [11:0] AVG7,
`ifdef ADC_PEAK_HOLD_EN
    input  logic        PEAK_CLR,
    output logic [11:0] PEAK0,
    output logic [11:0] PEAK1,
    output logic [11:0] PEAK2,
    output logic [11:0] PEAK3,
    output logic [11:0] PEAK4,
    output logic [11:0] PEAK5,
    output logic [11:0] PEAK6,
    output logic [11:0] PEAK7,
`endif
    output logic        AVG_VALID,
    output logic        BUSY
);
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int SCW   = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int IW    = $clog2(NUM_CH);
    localparam logic [SCW-1:0] SCNT_LAST = SCW'((1 << AVG_LOG2) - 1);

    logic             tick;
    state_e           state_q;
    logic [IW-1:0]    idx_q;
    logic [SCW-1:0]   scnt_q;
    adc_word_t        chan [NUM_CH];
    adc_word_t        snap_q [NUM_CH];
    logic [ACC_W-1:0] acc_q [NUM_CH];
    adc_word_t        avg_q [NUM_CH];
    logic             valid_q, busy_q;
    logic             last_blk;
    logic [ACC_W-1:0] sum_d;

    adc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .TICK  (tick)
    );

    assign chan     = '{CH0, CH1, CH2, CH3, CH4, CH5, CH6, CH7};
    assign last_blk = scnt_q == SCNT_LAST;
    // One shared adder walks the channels; ACC_W bits hold 2^AVG_LOG2 full-scale words.
    assign sum_d    = acc_q[idx_q] + ACC_W'(snap_q[idx_q]);

    always_ff @(posedge CLOCK or negedge RESET)
        if (!RESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            scnt_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap_q[k] <= '0;
                acc_q[k]  <= '0;
                avg_q[k]  <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (tick) begin
                    for (int k = 0; k < NUM_CH; k++) snap_q[k] <= chan[k];
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= SCAN;
                end
                SCAN: begin
                    acc_q[idx_q] <= last_blk ? '0 : sum_d;
                    if (last_blk) avg_q[idx_q] <= ADC_W'(sum_d >> AVG_LOG2);
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == IW'(NUM_CH - 1)) begin
                        valid_q <= last_blk;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    scnt_q  <= last_blk ? '0 : scnt_q + SCW'(1);
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end

    assign {AVG0, AVG1, AVG2, AVG3} = {avg_q[0], avg_q[1], avg_q[2], avg_q[3]};
    assign {AVG4, AVG5, AVG6, AVG7} = {avg_q[4], avg_q[5], avg_q[6], avg_q[7]};
    assign AVG_VALID = valid_q;
    assign BUSY      = busy_q;

`ifdef ADC_PEAK_HOLD_EN
    adc_word_t peak_q [NUM_CH];

    always_ff @(posedge CLOCK or negedge RESET)
        if (!RESET)
            for (int k = 0; k < NUM_CH; k++) peak_q[k] <= '0;
        else if (PEAK_CLR)
            for (int k = 0; k < NUM_CH; k++) peak_q[k] <= '0;
        else if (state_q == SCAN && snap_q[idx_q] > peak_q[idx_q])
            peak_q[idx_q] <= snap_q[idx_q];

    assign {PEAK0, PEAK1, PEAK2, PEAK3} = {peak_q[0], peak_q[1], peak_q[2], peak_q[3]};
    assign {PEAK4, PEAK5, PEAK6, PEAK7} = {peak_q[4], peak_q[5], peak_q[6], peak_q[7]};
`endif

    // TICK_DIV >= 10 keeps every scan inside one tick period.
    tick_only_in_idle: assert property (@(posedge CLOCK) disable iff (!RESET) tick |-> state_q == IDLE);
endmodule

// File: tb/tb_adc_chan_avg.sv
// tb_adc_chan_avg: three averaging depths (16, 1, 256 samples) against a sample-list reference model.
module tb_adc_chan_avg;
    localparam int TD = 10;

    typedef struct {
        int base;
        int step;
        int exp0;
        int exp7;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] ch [8];
    logic [11:0] av [3][8];
    logic        vld [3];
    logic        bsy [3];
`ifdef ADC_PEAK_HOLD_EN
    logic        peak_clr = 1'b0;
    logic [11:0] pk [3][8];
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n = 0;
    int cnt_m [3];
    int valid_at [3] = '{-1, -1, -1};
    int sum_m [3][8];
    int exp_avg [3][8];
    vec_t vecs [4];

    always #5 clk = ~clk;

    function automatic int nl(int i);
        return i == 0 ? 4 : (i == 1 ? 0 : 8);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        adc_chan_avg #(.TICK_DIV(TD), .AVG_LOG2(g == 0 ? 4 : (g == 1 ? 0 : 8))) u_dut (
            .CLOCK(clk), .RESET(rst_n),
            .CH0(ch[0]), .CH1(ch[1]), .CH2(ch[2]), .CH3(ch[3]),
            .CH4(ch[4]), .CH5(ch[5]), .CH6(ch[6]), .CH7(ch[7]),
            .AVG0(av[g][0]), .AVG1(av[g][1]), .AVG2(av[g][2]), .AVG3(av[g][3]),
            .AVG4(av[g][4]), .AVG5(av[g][5]), .AVG6(av[g][6]), .AVG7(av[g][7]),
`ifdef ADC_PEAK_HOLD_EN
            .PEAK_CLR(peak_clr),
            .PEAK0(pk[g][0]), .PEAK1(pk[g][1]), .PEAK2(pk[g][2]), .PEAK3(pk[g][3]),
            .PEAK4(pk[g][4]), .PEAK5(pk[g][5]), .PEAK6(pk[g][6]), .PEAK7(pk[g][7]),
`endif
            .AVG_VALID(vld[g]), .BUSY(bsy[g])
        );
    end

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: n is the cycle index since reset release; a tick is every TD-th cycle.
    // Each tick appends the raw channels to a block sum; a full block yields sum / 2^N, visible 9 cycles later.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            n = 0;
            for (int i = 0; i < 3; i++) begin
                cnt_m[i] = 0;
                valid_at[i] = -1;
                for (int k = 0; k < 8; k++) begin
                    sum_m[i][k] = 0;
                    exp_avg[i][k] = 0;
                end
            end
        end else begin
            if (n % TD == TD - 1)
                for (int i = 0; i < 3; i++) begin
                    for (int k = 0; k < 8; k++) sum_m[i][k] += int'(ch[k]);
                    cnt_m[i]++;
                    if (cnt_m[i] == (1 << nl(i))) begin
                        for (int k = 0; k < 8; k++) begin
                            exp_avg[i][k] = sum_m[i][k] / (1 << nl(i));
                            sum_m[i][k] = 0;
                        end
                        cnt_m[i] = 0;
                        valid_at[i] = n + 9;
                    end
                end
            n++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n)
            for (int i = 0; i < 3; i++) begin
                check($sformatf("valid%0d@%0d", i, n), int'(vld[i]), int'(n == valid_at[i]));
                check($sformatf("busy%0d@%0d", i, n), int'(bsy[i]), int'(n >= TD && n % TD != TD - 1));
                if (n == valid_at[i])
                    for (int k = 0; k < 8; k++)
                        check($sformatf("avg%0d_%0d@%0d", i, k, n), int'(av[i][k]), exp_avg[i][k]);
            end
    end

    task automatic reset_dut();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_tick();
        for (int i = 0; i < TD + 2; i++) begin
            @(negedge clk);
            if (n % TD == TD - 1) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_tick: no tick within %0d cycles", TD + 2);
    endtask

    task automatic wait_valid(int i, int bound);
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (vld[i]) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_valid%0d: no AVG_VALID within %0d cycles", i, bound);
    endtask

    task automatic set_all(int v);
        for (int k = 0; k < 8; k++) ch[k] = 12'(v);
    endtask

    initial begin
        vecs[0] = '{1000, 0, 1000, 1000};
        vecs[1] = '{0, 100, 0, 700};
        vecs[2] = '{4095, 0, 4095, 4095};
        vecs[3] = '{7, 500, 7, 3507};
        set_all(0);
        repeat (3) @(negedge clk);
        check("reset_avg0", int'(av[0][0]), 0);
        check("reset_valid", int'(vld[0]), 0);
        check("reset_busy", int'(bsy[0]), 0);
        #1 rst_n = 1'b1;

        foreach (vecs[v]) begin
            for (int k = 0; k < 8; k++) ch[k] = 12'(vecs[v].base + k * vecs[v].step);
            reset_dut();
            wait_valid(0, 16 * TD + 20);
            check($sformatf("vec%0d_first_valid_cycle", v), n, 16 * TD - 1 + 9);
            check($sformatf("vec%0d_avg0", v), int'(av[0][0]), vecs[v].exp0);
            check($sformatf("vec%0d_avg7", v), int'(av[0][7]), vecs[v].exp7);
        end

        for (int k = 0; k < 8; k++) ch[k] = 12'(k * 100);
        reset_dut();
        for (int t = 0; t < 16; t++) begin
            wait_tick();
            ch[0] = (t % 2) ? 12'd15 : 12'd0;
        end
        wait_valid(0, 20);
        check("alt_avg0", int'(av[0][0]), 7);
        check("alt_avg3", int'(av[0][3]), 300);

        set_all(500);
        ch[3] = 12'd200;
        reset_dut();
        for (int t = 0; t < 16; t++) begin
            wait_tick();
            ch[3] = 12'd200;
            repeat (2) @(negedge clk);
            ch[3] = 12'd4000;
        end
        wait_valid(0, 20);
        check("coherent_avg3", int'(av[0][3]), 200);
        ch[3] = 12'd200;

        set_all(4000);
        reset_dut();
        repeat (10) wait_tick();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midscan_rst_avg0", int'(av[0][0]), 0);
        check("midscan_rst_avg1", int'(av[1][5]), 0);
        check("midscan_rst_busy", int'(bsy[0]), 0);
        check("midscan_rst_valid", int'(vld[1]), 0);
        set_all(100);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_valid(0, 16 * TD + 20);
        check("post_rst_valid_cycle", n, 16 * TD - 1 + 9);
        check("post_rst_avg0", int'(av[0][0]), 100);

        set_all(4095);
        reset_dut();
        wait_valid(2, 256 * TD + 20);
        check("deep_avg0", int'(av[2][0]), 4095);
        check("deep_avg7", int'(av[2][7]), 4095);
        check("deep_valid_cycle", n, 256 * TD - 1 + 9);

        reset_dut();
        for (int c = 0; c < 2700; c++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) ch[k] = 12'($urandom_range(0, 4095));
        end

`ifdef ADC_PEAK_HOLD_EN
        set_all(0);
        reset_dut();
        wait_tick();
        ch[5] = 12'd10;
        wait_tick();
        ch[5] = 12'd900;
        wait_tick();
        ch[5] = 12'd30;
        wait_tick();
        check("peak5_max", int'(pk[0][5]), 900);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        check("peak5_clr", int'(pk[0][5]), 0);
        repeat (8) @(negedge clk);
        check("peak5_after_clr", int'(pk[0][5]), 30);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
